// File: rtl/xdma_pkg.sv
// Shared types and helpers for the xDMA write-side blocks.
package xdma_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  amo;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  size;
    logic        q_valid;
    logic        p_ready;
  } xdma_req_t;

  typedef struct packed {
    logic        q_ready;
    logic        p_valid;
    logic [31:0] data;
    logic        error;
  } xdma_rsp_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } xdma_arb_state_e;

  // Index fields are sized for the widest legal arbiter (8 requesters).
  typedef struct packed {
    xdma_arb_state_e state;
    logic [2:0]      rr;
    logic [2:0]      lock_idx;
    logic            fifo_empty;
  } xdma_arb_dbg_t;

  function automatic logic [2:0] rr_next(input logic [2:0] idx, input int unsigned n);
    if (32'(idx) + 32'd1 >= n) return 3'd0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Valid/ready FIFO; ready_o depends only on registered occupancy.
module stream_fifo #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 4,
  parameter type         T            = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  T     data_i,
  input  logic valid_i,
  output logic ready_o,
  output T     data_o,
  output logic valid_o,
  input  logic ready_i
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [AddrW-1:0] ptr_t;
  localparam ptr_t           LastPtr = ptr_t'(DEPTH - 1);
  localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(DEPTH);

  T               mem_q [DEPTH];
  ptr_t           wr_ptr_q, rd_ptr_q;
  logic [AddrW:0] cnt_q;
  logic           empty, fall, push, pop;

  assign empty   = (cnt_q == '0);
  assign fall    = FALL_THROUGH && empty && valid_i;
  assign ready_o = (cnt_q != FullCnt);
  assign valid_o = !empty || fall;
  assign data_o  = fall ? data_i : mem_q[rd_ptr_q];
  // A fall-through beat taken in the same cycle never touches storage.
  assign push    = valid_i && ready_o && !(fall && ready_i);
  assign pop     = valid_o && ready_i && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + ptr_t'(1);
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + ptr_t'(1);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/xdma_write_arbiter.sv
// Round-robin, burst-locked sharing of one reqrsp write port between NumInp
// requesters; an index FIFO routes the in-order responses back.
module xdma_write_arbiter
  import xdma_pkg::*;
#(
  parameter int unsigned NumInp         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         reqrsp_req_t   = xdma_req_t,
  parameter type         reqrsp_rsp_t   = xdma_rsp_t
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  reqrsp_req_t       in_req_i [NumInp],
  input  logic [NumInp-1:0] in_last_i,
  output reqrsp_rsp_t       in_rsp_o [NumInp],
  output reqrsp_req_t       out_req_o,
  input  reqrsp_rsp_t       out_rsp_i,
  output logic              busy_o,
  output xdma_arb_dbg_t     dbg_o
);

  localparam int unsigned IdxW = $clog2(NumInp);
  typedef logic [IdxW-1:0] idx_t;

  xdma_arb_state_e state_q, state_d;
  idx_t            rr_q, rr_d, lock_idx_q, lock_idx_d;
  idx_t            win_idx, cand, grant_idx, head_idx;
  logic            win_vld, grant_act, grant_vld;
  logic            fifo_ready, head_vld, accept, pop;
  logic [NumInp-1:0] q_valids;

  // Cyclic search starting at the round-robin pointer.
  always_comb begin
    win_idx = rr_q;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NumInp; k++) begin
      cand = idx_t'((32'(rr_q) + k) % NumInp);
      if (!win_vld && in_req_i[cand].q_valid) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // While locked the owner keeps the grant even with q_valid low.
  always_comb begin
    if (state_q == LOCKED) begin
      grant_idx = lock_idx_q;
      grant_act = 1'b1;
      grant_vld = in_req_i[lock_idx_q].q_valid;
    end else begin
      grant_idx = win_idx;
      grant_act = win_vld;
      grant_vld = win_vld;
    end
  end

  always_comb begin
    out_req_o         = in_req_i[grant_idx];
    out_req_o.q_valid = grant_vld && fifo_ready;
    out_req_o.p_ready = head_vld && in_req_i[head_idx].p_ready;
  end

  assign accept = out_req_o.q_valid && out_rsp_i.q_ready;
  assign pop    = head_vld && out_rsp_i.p_valid && out_req_o.p_ready;

  always_comb begin
    for (int unsigned i = 0; i < NumInp; i++) begin
      in_rsp_o[i] = '0;
      if (grant_act && grant_idx == idx_t'(i))
        in_rsp_o[i].q_ready = out_rsp_i.q_ready && fifo_ready;
      if (head_vld && head_idx == idx_t'(i)) begin
        in_rsp_o[i].p_valid = out_rsp_i.p_valid;
        in_rsp_o[i].data    = out_rsp_i.data;
        in_rsp_o[i].error   = out_rsp_i.error;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_idx_d = lock_idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rr_d = idx_t'(rr_next(3'(win_idx), NumInp));
          if (!in_last_i[win_idx]) begin
            state_d    = LOCKED;
            lock_idx_d = win_idx;
          end
        end
      end
      LOCKED: begin
        if (accept && in_last_i[lock_idx_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  stream_fifo #(
    .FALL_THROUGH(1'b0),
    .DEPTH       (MaxOutstanding),
    .T           (idx_t)
  ) i_idx_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(1'b0),
    .data_i (grant_idx),
    .valid_i(accept),
    .ready_o(fifo_ready),
    .data_o (head_idx),
    .valid_o(head_vld),
    .ready_i(pop)
  );

  always_comb begin
    for (int unsigned i = 0; i < NumInp; i++) q_valids[i] = in_req_i[i].q_valid;
  end

  assign busy_o = (|q_valids) || (state_q == LOCKED) || head_vld;

  assign dbg_o = '{state: state_q, rr: 3'(rr_q), lock_idx: 3'(lock_idx_q),
                   fifo_empty: !head_vld};

  p_valid_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_rsp_i.p_valid |-> head_vld);

endmodule

// File: tb/tb_xdma_write_arbiter.sv
// Directed bench for xdma_write_arbiter with two requesters, FIFO depth 4.
module tb_xdma_write_arbiter;
  import xdma_pkg::*;

  localparam int unsigned NumInp = 2;
  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  // Clock / reset
  logic clk;
  logic rst_ni;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  xdma_req_t         in_req [NumInp];
  logic [NumInp-1:0] in_last;
  xdma_rsp_t         in_rsp [NumInp];
  xdma_req_t         out_req;
  xdma_rsp_t         out_rsp;
  logic              busy;
  xdma_arb_dbg_t     dbg;

  xdma_write_arbiter #(
    .NumInp        (NumInp),
    .MaxOutstanding(4)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .in_req_i (in_req),
    .in_last_i(in_last),
    .in_rsp_o (in_rsp),
    .out_req_o(out_req),
    .out_rsp_i(out_rsp),
    .busy_o   (busy),
    .dbg_o    (dbg)
  );

  typedef struct {
    logic [1:0]  qv;
    logic [1:0]  last;
    logic        qr;
    logic        pv;
    logic [1:0]  pr;
    logic        e_qv;
    logic [31:0] e_addr;
    logic [1:0]  e_qr;
    logic [1:0]  e_pv;
    logic        e_pr;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic [1:0] qv, logic [1:0] last, logic qr, logic pv,
                              logic [1:0] pr, logic e_qv, logic [31:0] e_addr,
                              logic [1:0] e_qr, logic [1:0] e_pv, logic e_pr,
                              logic e_busy);
    vec_t v;
    v.qv = qv; v.last = last; v.qr = qr; v.pv = pv; v.pr = pr;
    v.e_qv = e_qv; v.e_addr = e_addr; v.e_qr = e_qr; v.e_pv = e_pv;
    v.e_pr = e_pr; v.e_busy = e_busy;
    return v;
  endfunction

  // Scoreboard check
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver
  task automatic drive(input logic [1:0] qv, input logic [1:0] last, input logic qr,
                       input logic pv, input logic [1:0] pr, input logic [31:0] rdata);
    for (int i = 0; i < int'(NumInp); i++) begin
      in_req[i].q_valid = qv[i];
      in_req[i].p_ready = pr[i];
      in_last[i]        = last[i];
    end
    out_rsp.q_ready = qr;
    out_rsp.p_valid = pv;
    out_rsp.data    = rdata;
    out_rsp.error   = 1'b0;
  endtask

  function automatic logic [1:0] qr_vec();
    return {in_rsp[1].q_ready, in_rsp[0].q_ready};
  endfunction

  function automatic logic [1:0] pv_vec();
    return {in_rsp[1].p_valid, in_rsp[0].p_valid};
  endfunction

  task automatic check_vec(input string tag, input vec_t v, input logic [31:0] rdata);
    check({tag, " out_qv"}, 32'(out_req.q_valid), 32'(v.e_qv));
    if (v.e_qv) check({tag, " out_addr"}, out_req.addr, v.e_addr);
    check({tag, " in_q_ready"}, 32'(qr_vec()), 32'(v.e_qr));
    check({tag, " in_p_valid"}, 32'(pv_vec()), 32'(v.e_pv));
    check({tag, " out_p_ready"}, 32'(out_req.p_ready), 32'(v.e_pr));
    check({tag, " busy"}, 32'(busy), 32'(v.e_busy));
    for (int j = 0; j < int'(NumInp); j++)
      if (v.e_pv[j]) check({tag, " rsp_data"}, in_rsp[j].data, rdata);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"}, 32'(dbg.state), 32'(IDLE));
    check({tag, " rr"}, 32'(dbg.rr), 32'd0);
    check({tag, " lock_idx"}, 32'(dbg.lock_idx), 32'd0);
    check({tag, " fifo_empty"}, 32'(dbg.fifo_empty), 32'd1);
    check({tag, " out_qv"}, 32'(out_req.q_valid), 32'd0);
    check({tag, " out_p_ready"}, 32'(out_req.p_ready), 32'd0);
    check({tag, " in_q_ready"}, 32'(qr_vec()), 32'd0);
    check({tag, " in_p_valid"}, 32'(pv_vec()), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < int'(NumInp); i++) begin
      in_req[i]      = '0;
      in_req[i].addr = (i == 0) ? A0 : A1;
      in_req[i].data = 32'hC0DE_0000 + 32'(i);
      in_req[i].amo  = 4'(i + 3);
      in_req[i].strb = 4'hF;
      in_req[i].size = 2'd2;
      in_req[i].write = 1'b1;
    end
    in_last = '0;
    out_rsp = '0;
    rst_ni  = 1'b0;

    // Alternating single beats, fill to full, one response frees a slot.
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(2'b11, 2'b11, 1, 0, 2'b11, 1, A0, 2'b01, 2'b00, k[0], 1));
      tbl.push_back(mk(2'b11, 2'b11, 1, 0, 2'b11, 1, A1, 2'b10, 2'b00, 1, 1));
    end
    tbl.push_back(mk(2'b11, 2'b11, 1, 0, 2'b11, 0, 0, 2'b00, 2'b00, 1, 1));
    tbl.push_back(mk(2'b11, 2'b11, 1, 1, 2'b11, 0, 0, 2'b00, 2'b01, 1, 1));
    tbl.push_back(mk(2'b11, 2'b11, 1, 0, 2'b11, 1, A0, 2'b01, 2'b00, 1, 1));
    // Drain FIFO [1,0,1,0]; head requester holds off once.
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b01, 0, 0, 2'b00, 2'b10, 0, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b11, 0, 0, 2'b00, 2'b01, 1, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b11, 0, 0, 2'b00, 2'b01, 1, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 2'b11, 0, 0, 2'b00, 2'b00, 0, 0));
    // Four-beat burst from input 1 while input 0 waits.
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 2'b11, 1, A1, 2'b10, 2'b00, 0, 1));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 2'b11, 1, A1, 2'b10, 2'b00, 1, 1));
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 2'b11, 1, A1, 2'b10, 2'b00, 1, 1));
    tbl.push_back(mk(2'b11, 2'b10, 1, 0, 2'b11, 1, A1, 2'b10, 2'b00, 1, 1));
    tbl.push_back(mk(2'b11, 2'b01, 1, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, 1));
    tbl.push_back(mk(2'b11, 2'b01, 1, 0, 2'b11, 1, A0, 2'b01, 2'b00, 1, 1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b11, 0, 0, 2'b00, 2'b01, 1, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 2'b11, 0, 0, 2'b00, 2'b00, 0, 0));
    // Locked input 1 stalls three cycles; input 0 must not slip in.
    tbl.push_back(mk(2'b11, 2'b00, 1, 0, 2'b11, 1, A1, 2'b10, 2'b00, 0, 1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(2'b01, 2'b00, 1, 0, 2'b11, 0, 0, 2'b10, 2'b00, 1, 1));
    tbl.push_back(mk(2'b11, 2'b10, 1, 0, 2'b11, 1, A1, 2'b10, 2'b00, 1, 1));
    // Downstream back-pressure, then accept.
    tbl.push_back(mk(2'b01, 2'b01, 0, 0, 2'b11, 1, A0, 2'b00, 2'b00, 1, 1));
    tbl.push_back(mk(2'b01, 2'b01, 1, 0, 2'b11, 1, A0, 2'b01, 2'b00, 1, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b11, 0, 0, 2'b00, 2'b10, 1, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, 2'b11, 0, 0, 2'b00, 2'b01, 1, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, 2'b11, 0, 0, 2'b00, 2'b00, 0, 0));

    // Reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_ni = 1'b1;

    foreach (tbl[r]) begin
      logic [31:0] rdata;
      rdata = 32'hD000_0000 + 32'(r);
      @(posedge clk);
      #1;
      drive(tbl[r].qv, tbl[r].last, tbl[r].qr, tbl[r].pv, tbl[r].pr, rdata);
      #3;
      check_vec($sformatf("row%0d", r), tbl[r], rdata);
    end

    // Mid-burst reset: lock input 0 with two beats in the FIFO.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      drive(2'b01, 2'b00, 1, 0, 2'b11, 0);
      #3;
      check($sformatf("lockbeat%0d out_addr", k), out_req.addr, A0);
      check($sformatf("lockbeat%0d out_qv", k), 32'(out_req.q_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    check("prereset state", 32'(dbg.state), 32'(LOCKED));
    check("prereset rr", 32'(dbg.rr), 32'd1);
    check("prereset fifo_empty", 32'(dbg.fifo_empty), 32'd0);
    drive(2'b00, 2'b00, 0, 0, 2'b00, 0);
    rst_ni = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    drive(2'b11, 2'b11, 1, 0, 2'b11, 0);
    #3;
    check("postreset out_addr", out_req.addr, A0);
    check("postreset in_q_ready", 32'(qr_vec()), 32'b01);
    check("postreset out_p_ready", 32'(out_req.p_ready), 32'd0);
    @(posedge clk);
    #1;
    drive(2'b00, 2'b00, 0, 0, 2'b00, 0);
    #3;
    check("postreset fifo_empty", 32'(dbg.fifo_empty), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
